// File: rtl/rr_arb2_mux.sv
// rtl/rr_arb2_mux.sv - two-port round-robin arbiter with packet lock and registered output
module rr_arb2_mux #(
    parameter int DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [DataWidth-1:0] a_data_i,
    input  logic [DataWidth-1:0] b_data_i,
    input  logic [1:0]           req_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_last_o,
    output logic [1:0]           grant_o,
    output logic [1:0]           owner_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_q;
    logic                 prio_q;
    logic [1:0]           owner_q;
    logic                 out_valid_q;
    logic [DataWidth-1:0] out_data_q;
    logic                 out_last_q;

    logic                 can_acc;
    logic                 acc_en;
    logic [1:0]           selected;
    logic [1:0]           grant;
    logic [DataWidth-1:0] out_data_d;
    logic                 out_last_d;

    // The output register has room when empty or being drained this cycle;
    // reset also masks the handshake so nothing is accepted while rst_ni is low.
    assign can_acc = ~out_valid_q | out_ready_i;
    assign acc_en  = can_acc & rst_ni;

    // Pick the requester allowed to transfer: the lock owner while a packet is
    // open, otherwise the sole valid requester or the one favoured by prio.
    always_comb begin
        selected = 2'b00;
        case (state_q)
            ST_IDLE: begin
                case (req_valid_i)
                    2'b01:   selected = 2'b01;
                    2'b10:   selected = 2'b10;
                    2'b11:   selected = prio_q ? 2'b10 : 2'b01;
                    default: selected = 2'b00;
                endcase
            end
            ST_LOCKED: selected = owner_q;
            default:   selected = 2'b00;
        endcase
    end

    assign grant       = selected & req_valid_i & {2{acc_en}};
    assign req_ready_o = selected & {2{acc_en}};
    assign grant_o     = grant;

    // One-hot AND-OR select so each bit maps onto a single AO22 cell.
    assign out_data_d = ({DataWidth{grant[0]}} & a_data_i) |
                        ({DataWidth{grant[1]}} & b_data_i);
    assign out_last_d = (grant[0] & req_last_i[0]) | (grant[1] & req_last_i[1]);

    // Lock/priority state machine and output register, updated on accepted beats.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (|grant) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            if (out_last_d) begin
                // Packet closed: release the lock and favour the other side.
                state_q <= ST_IDLE;
                owner_q <= 2'b00;
                prio_q  <= grant[0];
            end else begin
                state_q <= ST_LOCKED;
                owner_q <= grant;
            end
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_rr_arb2_mux.sv
// tb/tb_rr_arb2_mux.sv - directed and random scoreboard bench for rr_arb2_mux
module tb_rr_arb2_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] valid;
    logic [1:0] ready;
    logic [7:0] a_d;
    logic [7:0] b_d;
    logic [1:0] last;
    logic       o_valid;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_last;
    logic [1:0] grant;
    logic [1:0] owner;

    int checks = 0;
    int errors = 0;

    // scoreboard entry: {source id, last, data}
    logic [9:0] exp_q[$];
    logic       in_pkt = 1'b0;
    logic       pkt_src = 1'b0;
    logic [1:0] acc;
    int         seq[2];
    logic [1:0] cur_last;

    rr_arb2_mux #(.DataWidth(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (valid),
        .req_ready_o (ready),
        .a_data_i    (a_d),
        .b_data_i    (b_d),
        .req_last_i  (last),
        .out_valid_o (o_valid),
        .out_ready_i (o_ready),
        .out_data_o  (o_data),
        .out_last_o  (o_last),
        .grant_o     (grant),
        .owner_o     (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Runs at the negedge: consume the registered beat, then record the new one.
    task automatic monitor();
        logic [9:0] e;
        chk("onehot_grant", {31'd0, $onehot0(grant)}, 32'd1);
        chk("onehot_ready", {31'd0, $onehot0(ready)}, 32'd1);
        chk("onehot_owner", {31'd0, $onehot0(owner)}, 32'd1);
        if (o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", {23'd0, o_last, o_data}, 32'h1ff);
            end else begin
                e = exp_q.pop_front();
                chk("sb_beat", {23'd0, o_last, o_data}, {23'd0, e[8:0]});
                if (in_pkt) chk("sb_no_interleave", {31'd0, e[9]}, {31'd0, pkt_src});
                in_pkt  = ~e[8];
                pkt_src = e[9];
            end
        end
        acc = valid & ready;
        if (acc[0]) exp_q.push_back({1'b0, last[0], a_d});
        if (acc[1]) exp_q.push_back({1'b1, last[1], b_d});
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    initial begin
        rst_n = 1'b0; valid = 2'b11; last = 2'b11; a_d = 8'h11; b_d = 8'h22; o_ready = 1'b1;
        seq[0] = 0; seq[1] = 0; cur_last = 2'b00;

        // reset: handshake masked, registers cleared
        half();
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_ready", {30'd0, ready}, 32'd0);
        fin();
        step();
        chk("rst_out_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_out_data", {24'd0, o_data}, 32'd0);
        chk("rst_out_last", {31'd0, o_last}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);

        // both requesters, single-beat packets: strict alternation A,B,A,B
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            half();
            chk("alt_grant", {30'd0, grant}, (i % 2 == 0) ? 32'd1 : 32'd2);
            fin();
            chk("alt_data", {24'd0, o_data}, (i % 2 == 0) ? 32'h11 : 32'h22);
            chk("alt_valid", {31'd0, o_valid}, 32'd1);
        end

        // A 3-beat packet locks out B, B follows right after A's last beat
        valid = 2'b11; b_d = 8'hB0; last = 2'b10;
        for (int i = 0; i < 3; i++) begin
            a_d = 8'hA0 + 8'(i);
            last[0] = (i == 2);
            half();
            chk("lock_grant", {30'd0, grant}, 32'd1);
            chk("lock_ready", {30'd0, ready}, 32'd1);
            fin();
            chk("lock_data", {24'd0, o_data}, 32'hA0 + i);
            chk("lock_owner", {30'd0, owner}, (i == 2) ? 32'd0 : 32'd1);
        end
        a_d = 8'hA3; last = 2'b11;
        half();
        chk("after_lock_grant", {30'd0, grant}, 32'd2);
        fin();
        chk("after_lock_data", {24'd0, o_data}, 32'hB0);
        valid = 2'b00;
        step();

        // back-pressure: one beat taken, then stable for 4 stalled cycles
        valid = 2'b01; a_d = 8'hC0; last = 2'b11; o_ready = 1'b0;
        half();
        chk("bp_first_grant", {30'd0, grant}, 32'd1);
        fin();
        chk("bp_first_data", {24'd0, o_data}, 32'hC0);
        a_d = 8'hC1;
        for (int i = 0; i < 4; i++) begin
            half();
            chk("bp_stall_grant", {30'd0, grant}, 32'd0);
            chk("bp_stall_ready", {30'd0, ready}, 32'd0);
            fin();
            chk("bp_stall_data", {24'd0, o_data}, 32'hC0);
            chk("bp_stall_valid", {31'd0, o_valid}, 32'd1);
        end
        o_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            a_d = 8'hC0 + 8'(i);
            half();
            chk("bp_resume_grant", {30'd0, grant}, 32'd1);
            fin();
            chk("bp_resume_data", {24'd0, o_data}, 32'hC0 + i);
        end
        valid = 2'b00;
        step();

        // mid-packet gap from A: B stays blocked until A's last beat
        valid = 2'b01; a_d = 8'hD0; last = 2'b10; b_d = 8'hE0;
        half();
        chk("gap_first_grant", {30'd0, grant}, 32'd1);
        fin();
        chk("gap_owner", {30'd0, owner}, 32'd1);
        valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            half();
            chk("gap_grant", {30'd0, grant}, 32'd0);
            chk("gap_ready", {30'd0, ready}, 32'd1);
            fin();
            chk("gap_hold_owner", {30'd0, owner}, 32'd1);
        end
        valid = 2'b11; a_d = 8'hD1; last = 2'b11;
        half();
        chk("gap_last_grant", {30'd0, grant}, 32'd1);
        fin();
        chk("gap_last_data", {24'd0, o_data}, 32'hD1);
        chk("gap_release_owner", {30'd0, owner}, 32'd0);
        half();
        chk("gap_b_grant", {30'd0, grant}, 32'd2);
        fin();
        chk("gap_b_data", {24'd0, o_data}, 32'hE0);
        valid = 2'b00;
        step();

        // reset while locked with a buffered beat
        valid = 2'b01; a_d = 8'hF0; last = 2'b10; o_ready = 1'b0;
        half();
        chk("mrst_grant", {30'd0, grant}, 32'd1);
        fin();
        chk("mrst_locked", {30'd0, owner}, 32'd1);
        chk("mrst_buffered", {31'd0, o_valid}, 32'd1);
        rst_n = 1'b0;
        half();
        chk("mrst_grant_in_reset", {30'd0, grant}, 32'd0);
        fin();
        chk("mrst_out_valid", {31'd0, o_valid}, 32'd0);
        chk("mrst_out_data", {24'd0, o_data}, 32'd0);
        chk("mrst_out_last", {31'd0, o_last}, 32'd0);
        chk("mrst_owner", {30'd0, owner}, 32'd0);
        exp_q.delete();
        in_pkt = 1'b0;
        rst_n = 1'b1; o_ready = 1'b1; valid = 2'b11; a_d = 8'h33; b_d = 8'h44; last = 2'b11;
        half();
        chk("mrst_a_wins", {30'd0, grant}, 32'd1);
        fin();
        chk("mrst_a_data", {24'd0, o_data}, 32'h33);
        valid = 2'b00;
        step();

        // random traffic: source data advances only on acceptance
        seq[0] = 0; seq[1] = 0;
        cur_last = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
        for (int c = 0; c < 3000; c++) begin
            valid   = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
            o_ready = ($urandom_range(0, 9) < 7);
            a_d     = {1'b0, 7'(seq[0])};
            b_d     = {1'b1, 7'(seq[1])};
            last    = cur_last;
            step();
            for (int r = 0; r < 2; r++) begin
                if (acc[r]) begin
                    seq[r]++;
                    cur_last[r] = ($urandom_range(0, 2) == 0);
                end
            end
        end
        valid = 2'b00; o_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rand_sb_empty", exp_q.size(), 32'd0);
        chk("rand_a_progress", {31'd0, (seq[0] > 100)}, 32'd1);
        chk("rand_b_progress", {31'd0, (seq[1] > 100)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb2_mux.md
# rr_arb2_mux

Two-port round-robin arbiter with packet lock that shares one registered output stream between two valid/ready requesters. Data selection is a one-hot AND-OR (a22o-form) mux, so it maps directly onto the library's discrete AND/AO cells. The block sits in front of any single-consumer resource, such as a shared bus or memory port, that two masters must time-share on packet boundaries.

## Interface
- DataWidth, 8, width of each data beat
- clk_i  input  1  clock, all logic on rising edge
- rst_ni  input  1  synchronous, active-low reset
- req_valid_i  input  2  per-requester beat valid; bit 0 = requester A, bit 1 = requester B
- req_ready_o  output  2  per-requester beat accepted
- a_data_i  input  DataWidth  requester A beat data
- b_data_i  input  DataWidth  requester B beat data
- req_last_i  input  2  per-requester end-of-packet marker
- out_valid_o  output  1  output register holds a beat
- out_ready_i  input  1  consumer accepts output beat
- out_data_o  output  DataWidth  registered muxed data
- out_last_o  output  1  registered last marker of the beat
- grant_o  output  2  one-hot requester whose beat is accepted this cycle, 00 if none (combinational)
- owner_o  output  2  registered one-hot lock owner, 00 when idle

## Operation
- Free slot: `can_acc = !out_valid_o | out_ready_i`.
- Priority pointer `prio`: 0 favours A, 1 favours B. Reset value 0.
- States:
  - IDLE
    - Exactly one requester valid: that requester gets the grant.
    - Both valid: the requester selected by `prio` gets the grant.
    - None valid: no grant.
  - LOCKED
    - Only `owner_o` can be granted.
    - The other requester is blocked even if the owner deasserts valid. There is no timeout.
- Grant and accept:
  - `grant_o[i] = selected[i] & req_valid_i[i] & can_acc`.
  - `req_ready_o[i] = selected[i] & can_acc`.
  - In IDLE, `req_ready_o` depends combinationally on `req_valid_i`. This is permitted.
- Data mux: `out_data_d = ({DataWidth{grant_o[0]}} & a_data_i) | ({DataWidth{grant_o[1]}} & b_data_i)`. The last marker uses the same form.
- Accepted beat with last = 0:
  - Go to LOCKED (or stay there).
  - `owner_o` becomes the granted requester.
- Accepted beat with last = 1:
  - Go to IDLE and set `owner_o` = 00.
  - Set `prio` to the requester that was not served.
  - A single-beat packet accepted in IDLE stays in IDLE.
- Output register:
  - Loads on any grant.
  - If there is no grant and `out_ready_i` = 1, `out_valid_o` clears; data and last keep their old values.
  - If `out_valid_o` = 1 and `out_ready_i` = 0, data and last stay stable and no grant occurs.

## Timing
- Reset (`rst_ni` low at a clock edge): `out_valid_o` = 0, `out_data_o` = 0, `out_last_o` = 0, `owner_o` = 00, state IDLE, `prio` = 0.
- `req_ready_o` and `grant_o` are 00 while `rst_ni` is low.
- Reset mid-packet discards the lock and any buffered beat. The beat is not replayed.
- Latency: a beat accepted at edge N appears on `out_data_o` / `out_valid_o` after edge N.
- Throughput: 1 beat/cycle when `out_ready_i` is held high. Drain and refill of the output register in the same cycle is required (`can_acc` includes `out_ready_i`).
- Priority change takes effect the cycle after the last beat.
  - Back-to-back packets from alternating requesters need no idle cycle.
  - A requester whose last beat just transferred can be regranted next cycle only if the other requester is not valid.
- At most one bit of `grant_o`, `req_ready_o` and `owner_o` is set in any cycle.

## Test plan
- Reset, then `req_valid_i` = 11, both last = 1, A data 0x11, B data 0x22, `out_ready_i` = 1:
  - Outputs must be 0x11, 0x22, 0x11, 0x22 on consecutive cycles.
  - `grant_o` must alternate 01, 10.
- A sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last) while B is valid the whole time:
  - `owner_o` = 01 after beat 1; B stays not-ready.
  - B's first beat is output on the cycle after 0xA2.
- Back-pressure:
  - Hold `out_ready_i` = 0 for 4 cycles with A valid: `out_data_o` stays stable; only one beat is accepted before the stall.
  - Release `out_ready_i`: one beat per cycle resumes with no loss or duplication.
- Mid-packet source gap:
  - A sends a non-last beat, then deasserts valid for 3 cycles while B is valid.
  - B must never be granted until A's last beat transfers.
- Reset mid-packet:
  - Assert `rst_ni` = 0 while LOCKED with `out_valid_o` = 1.
  - After release, all outputs are at reset values, `prio` = 0, and A wins the next simultaneous request.
- Random valid/ready/last traffic with a scoreboard:
  - Per-requester order is preserved and no beat is lost or duplicated.
  - Packets are never interleaved.
